assoc_cache: RTL and testbench
==============================

# assoc_cache

Parametrised set-associative data cache placed between the core's ALU result / store-data path and the data memory, replacing the fixed direct-mapped cache. It adds configurable ways, sets and line length, multi-word line refill over a request/acknowledge handshake, write-through stores with byte strobes, and a stall output that freezes the core's PC while a miss or store completes. Read hits return data combinationally in the request cycle, so the single-cycle datapath keeps its zero-wait-state behaviour on hits.

## Interface
- ADDR_WIDTH, 32, byte address width
- DATA_WIDTH, 32, word width; multiple of 8
- SETS, 64, number of sets; power of two, ≥2
- WAYS, 2, associativity; power of two, ≥1
- LINE_WORDS, 4, words per line; power of two, ≥1
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  reset; asynchronous, active-low
- req_valid  input  1  core access request
- req_we  input  1  1 = store, 0 = load
- req_addr  input  ADDR_WIDTH  byte address; bits [log2(DATA_WIDTH/8)-1:0] ignored
- req_wdata  input  DATA_WIDTH  store data
- req_wstrb  input  DATA_WIDTH/8  store byte enables
- rsp_rdata  output  DATA_WIDTH  load data; valid when req_valid & !req_we & !stall
- stall  output  1  core must hold the request and PC
- mem_req  output  1  backing-memory request
- mem_we  output  1  backing-memory write
- mem_addr  output  ADDR_WIDTH  word-aligned backing address
- mem_wdata  output  DATA_WIDTH  write data
- mem_wstrb  output  DATA_WIDTH/8  write byte enables
- mem_ack  input  1  beat complete; mem_rdata valid this cycle for reads
- mem_rdata  input  DATA_WIDTH  read data
- total_accesses, total_hits, total_misses  output  32 each  statistics counters

## Operation
- Address split (LSB up): byte offset, word offset log2(LINE_WORDS), index log2(SETS), tag = remainder.
- Per way per set: valid bit, tag, LINE_WORDS data words. Per set: round-robin victim pointer, log2(WAYS) bits.
- Hit = any way valid with matching tag. At most one way may match.
- States: IDLE, REFILL, WRITE.
- IDLE, no request: stall=0, mem_req=0.
- IDLE, read hit: rsp_rdata = matching way's word; stall=0; stay IDLE.
- IDLE, read miss: stall=1; latch line base address; victim = lowest-index invalid way, else the set's pointer; go to REFILL with beat counter 0.
- REFILL: mem_req=1, mem_we=0, mem_addr = line base + beat×(DATA_WIDTH/8). On mem_ack write mem_rdata into victim word[beat], beat++. On the last beat's ack: write tag, set valid, advance set pointer (mod WAYS) if victim came from pointer, set retry flag, go to IDLE. Victim valid cleared on REFILL entry.
- IDLE with retry flag set: held request hits; flag cleared on that cycle.
- IDLE, store (hit or miss): stall=1, go to WRITE; store data/strobes/address latched.
- WRITE: mem_req=1, mem_we=1, address/data/strobes from latch. On mem_ack: if hit, merge strobed bytes into cached word; stall=0 in the ack cycle; go to IDLE. No write-allocate: store miss leaves the cache unchanged.
- Counters (per new request, retry cycle excluded): total_accesses +1; total_hits +1 on hit; total_misses +1 on miss. Wrap at 2^32.

## Timing
- Reset (rst low, any state, takes effect immediately): state IDLE, all valid bits 0, pointers 0, retry 0, counters 0, mem_req 0, mem_we 0, stall 0, mem_addr/mem_wdata/mem_wstrb 0, rsp_rdata 0 while no hit. Refill/write aborted; partial line discarded.
- Read hit: 0 wait cycles.
- Read miss: stall high from request cycle through the retry cycle's preceding edge; with a k-cycle ack latency, stall cycles = LINE_WORDS×k + 1.
- Store: stall high until the mem_ack cycle; with k-cycle latency, k stall cycles, core advances on the ack edge.
- mem_req/mem_addr held stable until mem_ack; next beat may be requested the cycle after ack (mem_req stays high, address advances).
- mem_ack while mem_req=0: ignored.
- Core must not change req_* while stall=1; behaviour otherwise undefined.
- req_valid=0 in IDLE: no state change, no counting.

## Configuration
- CACHE_STATS_EN defined: three 32-bit counters implemented as above.
- Not defined: counters and retry-exclusion logic removed; total_accesses/total_hits/total_misses tied to 0. Cache function unchanged.

## Test plan
- Bench: SETS=4, WAYS=2, LINE_WORDS=4, mem_ack latency 1. Reset mid-REFILL (assert rst after 2 beats) -> mem_req 0 at once; later read to same address misses again; counters 0.
- Read 0x100 cold -> stall 5 cycles, mem_addr 0x100,0x104,0x108,0x10C; retry returns mem word; read 0x108 -> hit, 0 wait; counters 2/1/1.
- Reads 0x000, 0x040, 0x080 (same set 0) -> third miss evicts way 0 (0x000); read 0x040 hits; read 0x000 misses.
- Store 0xDEADBEEF wstrb 0b0011 to cached 0x104 (old 0x11223344) -> one mem write, stall 1 cycle; read 0x104 -> 0x1122BEEF, hit.
- Store to uncached 0x200 -> mem write issued; subsequent read 0x200 misses (no allocate).
- Counter check after 10 reads to one cached word -> accesses += 10, hits += 10, misses unchanged; without CACHE_STATS_EN all three read 0.

Source files
------------

// File: rtl/assoc_cache_if.sv
// Purpose: bus bundle for assoc_cache (core request/response side and
//          backing-memory side).
// Modports:
//   master - environment view: drives core requests and memory responses
//   slave  - cache view: answers the core, issues backing-memory beats
interface assoc_cache_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

  logic                  req_valid;
  logic                  req_we;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic [STRB_WIDTH-1:0] req_wstrb;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  stall;

  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [STRB_WIDTH-1:0] mem_wstrb;
  logic                  mem_ack;
  logic [DATA_WIDTH-1:0] mem_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_wstrb, mem_ack, mem_rdata,
    input  rsp_rdata, stall, mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_wstrb, mem_ack, mem_rdata,
    output rsp_rdata, stall, mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb
  );
endinterface

// File: rtl/assoc_cache.sv
// Purpose: parametrised set-associative, write-through, no-write-allocate
//          data cache with multi-word line refill and core stall.
// Ports:
//   clk, rst_n        - clock, asynchronous active-low reset
//   bus (slave)       - core req/rsp/stall and backing-memory handshake
//   total_accesses_o  - new requests seen (0 unless CACHE_STATS_EN)
//   total_hits_o      - new requests that hit (0 unless CACHE_STATS_EN)
//   total_misses_o    - new requests that missed (0 unless CACHE_STATS_EN)
// Build option: define CACHE_STATS_EN to implement the statistics counters.
module assoc_cache #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned SETS       = 64,
  parameter int unsigned WAYS       = 2,
  parameter int unsigned LINE_WORDS = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  assoc_cache_if.slave       bus,
  output logic [31:0]        total_accesses_o,
  output logic [31:0]        total_hits_o,
  output logic [31:0]        total_misses_o
);
  localparam int unsigned STRB_W = DATA_WIDTH / 8;
  localparam int unsigned BOFF   = $clog2(STRB_W);
  localparam int unsigned WOFF   = $clog2(LINE_WORDS);
  localparam int unsigned IDXW   = $clog2(SETS);
  localparam int unsigned TAGW   = ADDR_WIDTH - BOFF - WOFF - IDXW;
  localparam int unsigned WORDW  = (WOFF > 0) ? WOFF : 1;
  localparam int unsigned WAYW   = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam logic [ADDR_WIDTH-1:0] LINE_MASK =
    ~((ADDR_WIDTH'(1) << (BOFF + WOFF)) - ADDR_WIDTH'(1));
  localparam logic [ADDR_WIDTH-1:0] WORD_MASK =
    ~((ADDR_WIDTH'(1) << BOFF) - ADDR_WIDTH'(1));

  typedef enum logic [1:0] {S_IDLE, S_REFILL, S_WRITE} state_e;

  state_e state_q, state_d;

  logic                  valid_q [SETS][WAYS];
  logic [TAGW-1:0]       tag_q   [SETS][WAYS];
  logic [DATA_WIDTH-1:0] data_q  [SETS][WAYS][LINE_WORDS];
  logic [WAYW-1:0]       ptr_q   [SETS];

  logic [WORDW-1:0]      beat_q;
  logic [ADDR_WIDTH-1:0] line_q;
  logic [WAYW-1:0]       vic_q;
  logic                  vic_ptr_q;
  logic [ADDR_WIDTH-1:0] st_addr_q;
  logic [DATA_WIDTH-1:0] st_data_q;
  logic [STRB_W-1:0]     st_strb_q;
  logic                  st_hit_q;
  logic [WAYW-1:0]       st_way_q;

  // Field extraction for the live request, the refill line and the latched store
  logic [IDXW-1:0]  req_idx, line_idx, st_idx;
  logic [TAGW-1:0]  req_tag, line_tag;
  logic [WORDW-1:0] req_word, st_word;
  logic             last_beat;

  assign req_idx   = IDXW'(bus.req_addr >> (BOFF + WOFF));
  assign req_tag   = TAGW'(bus.req_addr >> (BOFF + WOFF + IDXW));
  assign req_word  = WORDW'(bus.req_addr >> BOFF) & WORDW'(LINE_WORDS - 1);
  assign line_idx  = IDXW'(line_q >> (BOFF + WOFF));
  assign line_tag  = TAGW'(line_q >> (BOFF + WOFF + IDXW));
  assign st_idx    = IDXW'(st_addr_q >> (BOFF + WOFF));
  assign st_word   = WORDW'(st_addr_q >> BOFF) & WORDW'(LINE_WORDS - 1);
  assign last_beat = (beat_q == WORDW'(LINE_WORDS - 1));

  // Tag lookup and victim choice (lowest invalid way, else round-robin pointer)
  logic            lookup_hit, inv_found;
  logic [WAYW-1:0] lookup_way, inv_way, victim_way;

  always_comb begin
    lookup_hit = 1'b0;
    lookup_way = '0;
    inv_found  = 1'b0;
    inv_way    = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[req_idx][w] && (tag_q[req_idx][w] == req_tag)) begin
        lookup_hit = 1'b1;
        lookup_way = WAYW'(w);
      end
    end
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_q[req_idx][w]) begin
        inv_found = 1'b1;
        inv_way   = WAYW'(w);
      end
    end
  end

  assign victim_way    = inv_found ? inv_way : ptr_q[req_idx];
  assign bus.rsp_rdata = (bus.req_valid && lookup_hit) ?
                         data_q[req_idx][lookup_way][req_word] : '0;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          if (bus.req_we)       state_d = S_WRITE;
          else if (!lookup_hit) state_d = S_REFILL;
        end
      end
      S_REFILL: if (bus.mem_ack && last_beat) state_d = S_IDLE;
      S_WRITE:  if (bus.mem_ack)              state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Stall and backing-memory outputs
  always_comb begin
    bus.stall     = 1'b0;
    bus.mem_req   = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.mem_wstrb = '0;
    case (state_q)
      S_IDLE: bus.stall = bus.req_valid && (bus.req_we || !lookup_hit);
      S_REFILL: begin
        bus.stall    = 1'b1;
        bus.mem_req  = 1'b1;
        bus.mem_addr = line_q | (ADDR_WIDTH'(beat_q) << BOFF);
      end
      S_WRITE: begin
        // Core is released in the ack cycle so it advances on that edge
        bus.stall     = !bus.mem_ack;
        bus.mem_req   = 1'b1;
        bus.mem_we    = 1'b1;
        bus.mem_addr  = st_addr_q;
        bus.mem_wdata = st_data_q;
        bus.mem_wstrb = st_strb_q;
      end
      default: ;
    endcase
  end

  // Control state: valid bits, victim pointers, refill and store latches
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_q    <= '0;
      line_q    <= '0;
      vic_q     <= '0;
      vic_ptr_q <= 1'b0;
      st_addr_q <= '0;
      st_data_q <= '0;
      st_strb_q <= '0;
      st_hit_q  <= 1'b0;
      st_way_q  <= '0;
      for (int s = 0; s < SETS; s++) begin
        ptr_q[s] <= '0;
        for (int w = 0; w < WAYS; w++) valid_q[s][w] <= 1'b0;
      end
    end else begin
      if (state_q == S_IDLE && bus.req_valid) begin
        if (bus.req_we) begin
          st_addr_q <= bus.req_addr & WORD_MASK;
          st_data_q <= bus.req_wdata;
          st_strb_q <= bus.req_wstrb;
          st_hit_q  <= lookup_hit;
          st_way_q  <= lookup_way;
        end else if (!lookup_hit) begin
          line_q    <= bus.req_addr & LINE_MASK;
          beat_q    <= '0;
          vic_q     <= victim_way;
          vic_ptr_q <= !inv_found;
          valid_q[req_idx][victim_way] <= 1'b0;
        end
      end
      if (state_q == S_REFILL && bus.mem_ack) begin
        beat_q <= beat_q + WORDW'(1);
        if (last_beat) begin
          valid_q[line_idx][vic_q] <= 1'b1;
          if (vic_ptr_q)
            ptr_q[line_idx] <= (ptr_q[line_idx] == WAYW'(WAYS - 1)) ?
                               '0 : ptr_q[line_idx] + WAYW'(1);
        end
      end
    end
  end

  // Tag/data arrays: refill beats and write-through merge on store hits
  always_ff @(posedge clk) begin
    if (state_q == S_REFILL && bus.mem_ack) begin
      data_q[line_idx][vic_q][beat_q] <= bus.mem_rdata;
      if (last_beat) tag_q[line_idx][vic_q] <= line_tag;
    end
    if (state_q == S_WRITE && bus.mem_ack && st_hit_q) begin
      for (int b = 0; b < STRB_W; b++)
        if (st_strb_q[b])
          data_q[st_idx][st_way_q][st_word][b*8 +: 8] <= st_data_q[b*8 +: 8];
    end
  end

`ifdef CACHE_STATS_EN
  // Statistics; the post-refill retry cycle re-presents an already counted request
  logic        retry_q;
  logic [31:0] acc_cnt_q, hit_cnt_q, miss_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retry_q    <= 1'b0;
      acc_cnt_q  <= '0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (state_q == S_REFILL && bus.mem_ack && last_beat) retry_q <= 1'b1;
      else if (state_q == S_IDLE)                          retry_q <= 1'b0;
      if (state_q == S_IDLE && bus.req_valid && !retry_q) begin
        acc_cnt_q <= acc_cnt_q + 32'd1;
        if (lookup_hit) hit_cnt_q  <= hit_cnt_q + 32'd1;
        else            miss_cnt_q <= miss_cnt_q + 32'd1;
      end
    end
  end

  assign total_accesses_o = acc_cnt_q;
  assign total_hits_o     = hit_cnt_q;
  assign total_misses_o   = miss_cnt_q;
`else
  assign total_accesses_o = '0;
  assign total_hits_o     = '0;
  assign total_misses_o   = '0;
`endif

endmodule

// File: tb/tb_assoc_cache.sv
// Directed bench for assoc_cache: SETS=4, WAYS=2, LINE_WORDS=4, one-cycle
// memory acknowledge. Backing memory returns 0x1000_0000|addr, except
// 0x104 = 0x11223344, overlaid by any completed writes.
module tb_assoc_cache;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] tot_acc, tot_hit, tot_miss;
  int          n_tests = 0;
  int          n_fail  = 0;

  always #5 clk = ~clk;

  assoc_cache_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  assoc_cache #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SETS(4), .WAYS(2), .LINE_WORDS(4)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .bus              (bus),
    .total_accesses_o (tot_acc),
    .total_hits_o     (tot_hit),
    .total_misses_o   (tot_miss)
  );

  // Backing memory model
  logic [31:0] wmem [1024];
  bit          wvld [1024];
  int          wr_cnt = 0;
  logic [31:0] wr_addr = '0, wr_data = '0;
  logic [3:0]  wr_strb = '0;
  logic [9:0]  ridx;

  function automatic logic [31:0] pat(input logic [31:0] a);
    return (a == 32'h104) ? 32'h1122_3344 : (32'h1000_0000 | a);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] cur, input logic [31:0] d,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = cur;
    for (int b = 0; b < 4; b++) if (s[b]) r[b*8 +: 8] = d[b*8 +: 8];
    return r;
  endfunction

  assign bus.mem_ack = bus.mem_req;

  always_comb begin
    ridx          = bus.mem_addr[11:2];
    bus.mem_rdata = wvld[ridx] ? wmem[ridx] : pat(bus.mem_addr);
  end

  always @(posedge clk) begin
    if (bus.mem_req && bus.mem_we && bus.mem_ack) begin
      wmem[bus.mem_addr[11:2]] <= merge(wvld[bus.mem_addr[11:2]] ? wmem[bus.mem_addr[11:2]]
                                        : pat(bus.mem_addr), bus.mem_wdata, bus.mem_wstrb);
      wvld[bus.mem_addr[11:2]] <= 1'b1;
      wr_cnt  <= wr_cnt + 1;
      wr_addr <= bus.mem_addr;
      wr_data <= bus.mem_wdata;
      wr_strb <= bus.mem_wstrb;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  logic [31:0] maddr_q [$];

  // One core access held until stall drops; counts stall cycles
  task automatic access(input string tag, input bit we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] wstrb,
                        input int exp_stalls, input logic [31:0] exp_data);
    int stalls = 0;
    bit done = 1'b0;
    maddr_q.delete();
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    bus.req_wstrb = wstrb;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (bus.mem_req) maddr_q.push_back(bus.mem_addr);
      if (!bus.stall) begin
        if (!we) check({tag, " rdata"}, bus.rsp_rdata, exp_data);
        done = 1'b1;
      end else begin
        stalls++;
      end
      @(posedge clk);
      #1;
    end
    bus.req_valid = 1'b0;
    check({tag, " completed"}, 32'(done), 32'd1);
    check({tag, " stall cycles"}, 32'(stalls), 32'(exp_stalls));
  endtask

  task automatic check_stats(input string tag, input int a, input int h, input int m);
`ifdef CACHE_STATS_EN
    check({tag, " accesses"}, tot_acc,  32'(a));
    check({tag, " hits"},     tot_hit,  32'(h));
    check({tag, " misses"},   tot_miss, 32'(m));
`else
    check({tag, " accesses"}, tot_acc,  32'(a - a));
    check({tag, " hits"},     tot_hit,  32'(h - h));
    check({tag, " misses"},   tot_miss, 32'(m - m));
`endif
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.req_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0;
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.req_wstrb = '0;

    // Reset state
    #2;
    check("rst mem_req",   32'(bus.mem_req), 32'd0);
    check("rst stall",     32'(bus.stall),   32'd0);
    check("rst mem_addr",  bus.mem_addr,     32'd0);
    check("rst rsp_rdata", bus.rsp_rdata,    32'd0);
    check_stats("rst", 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Reset in the middle of a refill, after two beats
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b0;
    bus.req_addr  = 32'h100;
    @(negedge clk);
    check("midrst miss stall", 32'(bus.stall), 32'd1);
    @(posedge clk);
    @(posedge clk);
    @(posedge clk);
    #1;
    check("midrst beat2 req",  32'(bus.mem_req), 32'd1);
    check("midrst beat2 addr", bus.mem_addr,     32'h108);
    rst_n = 1'b0;
    bus.req_valid = 1'b0;
    #1;
    check("midrst mem_req", 32'(bus.mem_req), 32'd0);
    check("midrst stall",   32'(bus.stall),   32'd0);
    check_stats("midrst", 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Cold read: full refill then retry, then a hit in the same line
    access("rd100 cold", 1'b0, 32'h100, '0, '0, 5, 32'h1000_0100);
    check("rd100 beats", 32'(maddr_q.size()), 32'd4);
    if (maddr_q.size() == 4) begin
      check("rd100 beat0", maddr_q[0], 32'h100);
      check("rd100 beat1", maddr_q[1], 32'h104);
      check("rd100 beat2", maddr_q[2], 32'h108);
      check("rd100 beat3", maddr_q[3], 32'h10C);
    end
    access("rd108 hit", 1'b0, 32'h108, '0, '0, 0, 32'h1000_0108);
    check_stats("after rd108", 2, 1, 1);

    // Three lines into set 0: third evicts way 0
    do_reset();
    access("rd000 miss", 1'b0, 32'h000, '0, '0, 5, 32'h1000_0000);
    access("rd040 miss", 1'b0, 32'h040, '0, '0, 5, 32'h1000_0040);
    access("rd080 miss", 1'b0, 32'h080, '0, '0, 5, 32'h1000_0080);
    access("rd040 hit",  1'b0, 32'h040, '0, '0, 0, 32'h1000_0040);
    access("rd000 evicted", 1'b0, 32'h000, '0, '0, 5, 32'h1000_0000);
    check_stats("evict", 5, 1, 4);

    // Write-through store hit with partial strobes
    do_reset();
    access("rd104 fill", 1'b0, 32'h104, '0, '0, 5, 32'h1122_3344);
    w0 = wr_cnt;
    access("st104", 1'b1, 32'h104, 32'hDEAD_BEEF, 4'b0011, 1, '0);
    check("st104 writes", 32'(wr_cnt - w0), 32'd1);
    check("st104 addr",   wr_addr, 32'h104);
    check("st104 data",   wr_data, 32'hDEAD_BEEF);
    check("st104 strb",   32'(wr_strb), 32'h3);
    access("rd104 merged", 1'b0, 32'h104, '0, '0, 0, 32'h1122_BEEF);

    // Store miss: written through, not allocated
    w0 = wr_cnt;
    access("st200", 1'b1, 32'h200, 32'hCAFE_F00D, 4'b1111, 1, '0);
    check("st200 writes", 32'(wr_cnt - w0), 32'd1);
    check("st200 addr",   wr_addr, 32'h200);
    access("rd200 miss", 1'b0, 32'h200, '0, '0, 5, 32'hCAFE_F00D);
    check_stats("store", 5, 2, 3);

    // Ten hits to one cached word
    for (int i = 0; i < 10; i++)
      access("rd104 rep", 1'b0, 32'h104, '0, '0, 0, 32'h1122_BEEF);
    check_stats("rep", 15, 12, 3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
